// File: rtl/wlmont_pkg.sv
// Shared types and sizing helpers for the folded word-level Montgomery reducer.
// The default-parameter constants mirror a LOGQ=32, W=16 build.
package wlmont_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } wlmont_state_e;

   // Number of W-bit Montgomery steps needed to cover LOGQ bits.
   function automatic int wlmont_steps(input int logq, input int w);
      return (logq + w - 1) / w;
   endfunction

   function automatic int wlmont_cnt_w(input int l);
      return $clog2(l) + 1;
   endfunction

   localparam int L_DEF = wlmont_steps(32, 16);
   localparam int CNT_W = wlmont_cnt_w(L_DEF);

endpackage

// File: rtl/wlmont_step.sv
// One combinational word-level Montgomery step: T' = (T + q*((-T) mod 2^W)) / 2^W,
// using q = qH*2^W + 1 so the multiply only needs the high part of q.
module wlmont_step #(
   parameter int LOGQ = 32,
   parameter int W    = 16,
   parameter int LOGT = 2 * LOGQ
) (
   input  logic [LOGQ-W-1:0] i_qH,
   input  logic [LOGT-1:0]   i_T,
   output logic [LOGT-1:0]   o_T
);

   logic [W-1:0]    w_t2l;
   logic [W-1:0]    w_t2;
   logic            w_carry;
   logic [LOGQ-1:0] w_prod;

   assign w_t2l = i_T[W-1:0];
   assign w_t2  = -w_t2l;
   // Nonzero low word: either it or its negation has the top bit set.
   assign w_carry = w_t2[W-1] | w_t2l[W-1];
   // qH < 2^(LOGQ-W) and T2 < 2^W, so the product fits in LOGQ bits.
   assign w_prod = LOGQ'(i_qH) * LOGQ'(w_t2);

   assign o_T = LOGT'(w_prod) + (i_T >> W) + LOGT'(w_carry);

endmodule

// File: rtl/wlmont_iter.sv
// Folded word-level Montgomery reduction: L steps on one shared datapath, then a
// single conditional subtraction, behind a valid/ready handshake on each side.
module wlmont_iter
   import wlmont_pkg::*;
#(
   parameter int LOGQ = 32,
   parameter int W    = 16,
   parameter int LOGT = 2 * LOGQ
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [LOGQ-1:0] q,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [LOGT-1:0] in_T,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [LOGQ-1:0] out_R,
   output logic            busy
);

   localparam int L  = wlmont_steps(LOGQ, W);
   localparam int CW = wlmont_cnt_w(L);
   localparam logic [CW-1:0] CNT_LAST = CW'(L - 1);

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_STEP = STEP;
   localparam logic [1:0] S_FIX  = FIX;
   localparam logic [1:0] S_DONE = DONE;

   logic [1:0]      r_state;
   logic [CW-1:0]   r_cnt;
   logic [LOGT-1:0] r_T;
   logic [LOGQ-W-1:0] r_qH;
   logic [LOGQ-1:0] r_q;
   logic [LOGQ-1:0] r_R;
   logic            r_valid;

   logic [LOGT-1:0] w_T_next;
   logic            w_ge_q;
   logic [LOGQ-1:0] w_diff;

   wlmont_step #(
      .LOGQ (LOGQ),
      .W    (W),
      .LOGT (LOGT)
   ) u_step (
      .i_qH (r_qH),
      .i_T  (r_T),
      .o_T  (w_T_next)
   );

   // After L steps T < 2q, so a LOGQ-bit difference holds the reduced value.
   assign w_ge_q = r_T >= LOGT'(r_q);
   assign w_diff = r_T[LOGQ-1:0] - r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_T     <= '0;
         r_qH    <= '0;
         r_q     <= '0;
         r_R     <= '0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_T     <= in_T;
                  r_qH    <= q[LOGQ-1:W];
                  r_q     <= q;
                  r_cnt   <= '0;
                  r_state <= S_STEP;
               end
            end
            S_STEP: begin
               r_T   <= w_T_next;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_LAST) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_R     <= w_ge_q ? w_diff : r_T[LOGQ-1:0];
               r_valid <= 1'b1;
               r_state <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  r_valid <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Ready is held low for the whole reset pulse, not just until the first edge.
   assign in_ready  = (r_state == S_IDLE) && !rst;
   assign busy      = (r_state != S_IDLE);
   assign out_valid = r_valid;
   assign out_R     = r_R;

endmodule

// File: tb/tb_wlmont_iter.sv
// Bench for wlmont_iter: three parameterisations share one clock, stimulus bus and reset;
// results are compared against a bit-serial modular-halving reference.
module tb_wlmont_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] s_T;
   logic [31:0] s_q;
   logic [2:0]  s_iv;
   logic        s_or;

   logic        rdy_a, vld_a, busy_a;
   logic [13:0] r_a;
   logic        rdy_b, vld_b, busy_b;
   logic [13:0] r_b;
   logic        rdy_c, vld_c, busy_c;
   logic [31:0] r_c;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   wlmont_iter #(.LOGQ(14), .W(12)) u_a (
      .clk(clk), .rst(rst), .q(s_q[13:0]), .in_valid(s_iv[0]), .in_ready(rdy_a),
      .in_T(s_T[27:0]), .out_valid(vld_a), .out_ready(s_or), .out_R(r_a), .busy(busy_a)
   );
   wlmont_iter #(.LOGQ(14), .W(5)) u_b (
      .clk(clk), .rst(rst), .q(s_q[13:0]), .in_valid(s_iv[1]), .in_ready(rdy_b),
      .in_T(s_T[27:0]), .out_valid(vld_b), .out_ready(s_or), .out_R(r_b), .busy(busy_b)
   );
   wlmont_iter #(.LOGQ(32), .W(16)) u_c (
      .clk(clk), .rst(rst), .q(s_q), .in_valid(s_iv[2]), .in_ready(rdy_c),
      .in_T(s_T), .out_valid(vld_c), .out_ready(s_or), .out_R(r_c), .busy(busy_c)
   );

   typedef struct {
      int              sel;
      longint unsigned t;
      longint unsigned exp_r;
   } vec_t;

   vec_t vecs[9];

   function automatic longint unsigned q_of(input int sel);
      return (sel == 2) ? 64'd4293918721 : 64'd12289;
   endfunction

   // Total Montgomery shift L*W for each instance.
   function automatic int shift_of(input int sel);
      case (sel)
         0:       return 24;
         1:       return 15;
         default: return 32;
      endcase
   endfunction

   // L steps + 1 fix cycle.
   function automatic int lat_of(input int sel);
      return (sel == 1) ? 4 : 3;
   endfunction

   function automatic logic get_vld(input int sel);
      case (sel)
         0:       return vld_a;
         1:       return vld_b;
         default: return vld_c;
      endcase
   endfunction

   function automatic logic get_rdy(input int sel);
      case (sel)
         0:       return rdy_a;
         1:       return rdy_b;
         default: return rdy_c;
      endcase
   endfunction

   function automatic longint unsigned get_r(input int sel);
      case (sel)
         0:       return 64'(r_a);
         1:       return 64'(r_b);
         default: return 64'(r_c);
      endcase
   endfunction

   // T * 2^-n mod q by n modular halvings.
   function automatic longint unsigned ref_mont(input longint unsigned t,
                                                input longint unsigned qv, input int n);
      longint unsigned r;
      r = t % qv;
      for (int i = 0; i < n; i++) begin
         if (r[0]) r = r + qv;
         r = r >> 1;
      end
      return r;
   endfunction

   function automatic longint unsigned rand_t(input int sel);
      longint unsigned qv;
      longint unsigned raw;
      qv  = q_of(sel);
      raw = {$urandom, $urandom};
      return raw % (qv * qv);
   endfunction

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Called at a negedge just after the acceptance edge; returns edges until out_valid.
   task automatic wait_valid(input int sel, output int cyc);
      cyc = 0;
      while (!get_vld(sel) && cyc < 40) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic run_tx(input int sel, input longint unsigned t, input string name,
                         output longint unsigned r);
      int cyc;
      @(negedge clk);
      chk({name, "_ready_before"}, 64'(get_rdy(sel)), 64'd1);
      s_T = t;
      s_q = 32'(q_of(sel));
      s_iv[sel] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_iv = '0;
      s_T  = {$urandom, $urandom};
      s_q  = $urandom;
      wait_valid(sel, cyc);
      chk({name, "_latency"}, 64'(cyc), 64'(lat_of(sel)));
      r = get_r(sel);
      s_or = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_or = 1'b0;
      chk({name, "_ready_after"}, 64'(get_rdy(sel)), 64'd1);
   endtask

   initial begin
      longint unsigned r;
      longint unsigned t;
      int cyc;

      rst  = 1'b1;
      s_iv = '0;
      s_or = 1'b0;
      s_T  = '0;
      s_q  = '0;
      repeat (2) @(negedge clk);
      chk("reset_out_valid", 64'(vld_a), 64'd0);
      chk("reset_in_ready",  64'(rdy_a), 64'd0);
      chk("reset_busy",      64'(busy_a), 64'd0);
      chk("reset_out_R",     64'(r_a), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", 64'(rdy_a), 64'd1);

      vecs[0] = '{0, 64'd16777216, 64'd1};
      vecs[1] = '{0, 64'd12289,    64'd0};
      vecs[2] = '{0, 64'd0,        64'd0};
      vecs[3] = '{0, 64'd83886080, 64'd5};
      vecs[4] = '{1, 64'd229376,   64'd7};
      vecs[5] = '{1, 64'd12289,    64'd0};
      vecs[6] = '{2, 64'd21474836480, 64'd5};
      vecs[7] = '{2, 64'd4293918721,  64'd0};
      vecs[8] = '{2, 64'd4294967296,  64'd1};
      for (int i = 0; i < 9; i++) begin
         run_tx(vecs[i].sel, vecs[i].t, $sformatf("vec%0d", i), r);
         chk($sformatf("vec%0d_R", i), r, vecs[i].exp_r);
      end

      for (int sel = 0; sel < 3; sel++) begin
         t = q_of(sel) * q_of(sel) - 1;
         run_tx(sel, t, $sformatf("max%0d", sel), r);
         chk($sformatf("max%0d_R", sel), r, ref_mont(t, q_of(sel), shift_of(sel)));
         for (int k = 0; k < 12; k++) begin
            t = rand_t(sel);
            run_tx(sel, t, $sformatf("rnd%0d_%0d", sel, k), r);
            chk($sformatf("rnd%0d_%0d_R", sel, k), r, ref_mont(t, q_of(sel), shift_of(sel)));
         end
      end

      // Backpressure: result held, ready low, new offers ignored.
      @(negedge clk);
      s_T = 64'd16777216;
      s_q = 32'd12289;
      s_iv[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_iv = '0;
      wait_valid(0, cyc);
      chk("bp_latency", 64'(cyc), 64'd3);
      for (int i = 0; i < 10; i++) begin
         chk("bp_out_valid", 64'(vld_a), 64'd1);
         chk("bp_in_ready",  64'(rdy_a), 64'd0);
         chk("bp_out_R",     64'(r_a), 64'd1);
         s_iv[0] = 1'b1;
         s_T = 64'($urandom);
         @(posedge clk);
         @(negedge clk);
      end
      s_iv = '0;
      s_or = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_or = 1'b0;
      chk("bp_release_ready", 64'(rdy_a), 64'd1);
      chk("bp_release_valid", 64'(vld_a), 64'd0);
      run_tx(0, 64'd83886080, "bp_next", r);
      chk("bp_next_R", r, 64'd5);

      // Reset during the first STEP cycle.
      @(negedge clk);
      s_T = 64'd16777216;
      s_q = 32'd12289;
      s_iv[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_iv = '0;
      chk("mid_busy_before", 64'(busy_a), 64'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 64'(vld_a), 64'd0);
      chk("mid_rst_ready", 64'(rdy_a), 64'd0);
      chk("mid_rst_busy",  64'(busy_a), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_ready_hold", 64'(rdy_a), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rel_ready", 64'(rdy_a), 64'd1);
      chk("mid_rel_valid", 64'(vld_a), 64'd0);
      run_tx(0, 64'd16777216, "mid_next", r);
      chk("mid_next_R", r, 64'd1);

      // Reset while a result waits in DONE.
      @(negedge clk);
      s_T = 64'd83886080;
      s_q = 32'd12289;
      s_iv[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_iv = '0;
      wait_valid(0, cyc);
      chk("done_valid", 64'(vld_a), 64'd1);
      chk("done_R", 64'(r_a), 64'd5);
      rst = 1'b1;
      #1;
      chk("done_rst_valid", 64'(vld_a), 64'd0);
      chk("done_rst_R", 64'(r_a), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("done_rel_ready", 64'(rdy_a), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
